accu_core_hs: RTL and testbench
===============================

// Module: accu_core_hs
// PURPOSE
//  Second-generation accumulator CPU core. Same ISA family as the single-memory core, but talks to
//  external unified memory over a req/ack handshake with arbitrary wait states. Adds reset, HALT,
//  carry/zero flags and bounds-checked branches. Sits between the testbench/top and a memory or arbiter.
// PARAMETERS
//  DATA_SIZE     8   accumulator/data width; must be >= ADDR_SIZE
//  ADDR_SIZE     5   memory address width
//  OPCODE_SIZE   4   opcode width, held in instr[INSTR_SIZE-1 -: OPCODE_SIZE]
//  INSTR_SIZE    12  instruction word width; must be >= OPCODE_SIZE+DATA_SIZE
//  PROGRAM_SIZE  16  program words at addresses 0..PROGRAM_SIZE-1; must be <= 2**ADDR_SIZE
//  PA = $clog2(PROGRAM_SIZE), derived; the pc is PA+1 bits wide
// PORTS
//  clk            in   1           rising-edge clock
//  rst_n          in   1           asynchronous active-low reset
//  mem_req        out  1           transaction request
//  mem_we         out  1           1 = write (STORE), 0 = read
//  mem_addr       out  ADDR_SIZE   transaction address
//  mem_wdata      out  DATA_SIZE   write data; always equals acc
//  mem_rdata      in   INSTR_SIZE  read data; valid in any cycle where mem_ack=1
//  mem_ack        in   1           completes the transaction at a rising edge where mem_req&mem_ack
//  acc            out  DATA_SIZE   accumulator, signed
//  carry          out  1           carry flag
//  zero           out  1           1 when acc==0
//  pc             out  PA+1        program counter
//  halted         out  1           core stopped in HALT state
//  out_of_bounds  out  1           halted because the pc or a branch target left the program
// BEHAVIOUR
//  Reset (async, rst_n=0): state=FETCH. acc, carry, pc, halted, out_of_bounds, mem_req and mem_we are
//   all 0, and zero=1. Any open transaction is abandoned. No write may complete without req&ack at an edge.
//  FSM FETCH -> EXEC -> (FETCH | HALT).
//   FETCH: req=1, we=0, addr={0,pc}. On ack, latch mem_rdata into the instruction register and go to EXEC.
//   EXEC, operand op (LOAD/ADD/SUB/AND/OR/XOR/STORE): req=1, addr=instr[ADDR_SIZE-1:0], we=(STORE).
//    On ack, update acc/flags (or commit the write), advance pc and go to FETCH.
//   EXEC, other ops: complete in one cycle with req=0.
//   HALT: req=0; only reset leaves this state.
//  Handshake: addr/we/wdata are stable from req rise until the ack edge. req may drop the cycle after ack.
//   Zero-wait (ack tied 1): register op = 2 clk, memory op = 2 clk, with back-to-back req allowed.
//  Opcodes (m = mem_rdata[DATA_SIZE-1:0], k = instr[DATA_SIZE-1:0]):
//   0000 HALT         0001 LOAD acc=m        0010 ADD acc+=m        0011 SUB acc-=m
//   0100 AND          0101 OR                0110 XOR               0111 NOT acc=~acc
//   1000 SHR (arithmetic, sign kept)         1001 SHL               1010 LDI acc=k
//   1011 ADDI acc+=k  1100 STORE mem[a]=acc  1101 JZ               1110 JN
//   1111 JMP pc={0,acc[PA-1:0]}
//  Carry flag:
//   ADD/ADDI: carry = unsigned carry out of DATA_SIZE bits.
//   SUB: carry = 1 when there is no borrow (acc >= m, unsigned).
//   SHR/SHL: carry = the bit shifted out.
//   All other ops leave carry unchanged.
//  zero is combinational from acc. Arithmetic wraps modulo 2**DATA_SIZE.
//  JZ/JN: condition is acc==0 (JZ) or acc[DATA_SIZE-1] (JN). If taken, pc += signed instr[PA:0];
//   otherwise pc += 1.
//  Bounds: any new pc outside 0..PROGRAM_SIZE-1 (including the increment past the last word and negative
//   targets) sets out_of_bounds=1 and halted=1. pc keeps the offending value; no further fetch is made.
//  HALT opcode: halted=1 and out_of_bounds=0, entered at the EXEC edge; pc is not advanced.
//  Registers update only at the completing edge, so a wait-state stall leaves acc, flags and pc unchanged.
// TESTING
//  1 LDI 5; ADD [20] with mem[20]=3; HALT, zero-wait -> acc=8, carry=0, halted at pc=2, 6 clk after reset.
//  2 LDI 8'hF0; ADDI 8'h20 -> acc=8'h10, carry=1. Then SUB [20] with mem=8'h20 -> acc=8'hF0, carry=0.
//  3 ack delayed 3 cycles on every request -> req held 4 clk, addr/we stable, results same as test 1.
//  4 LDI 3; ADDI -1; JZ +2; JMP-loop back to ADDI -> exits with acc=0 after 3 passes, pc lands at target.
//  5 LDI 7; STORE [25]; LDI 0; LOAD [25] -> exactly one write (addr 25, data 7), final acc=7.
//  6 rst_n pulled low mid-wait with req=1 -> req=0 immediately; a dropped STORE write never lands;
//    fetch restarts at pc=0.
//  7 PROGRAM_SIZE=4 with no HALT -> after word 3, pc=4, out_of_bounds=1, halted=1, req stays 0.

Source files
------------

// File: rtl/accu_core_hs.sv
// accu_core_hs: accumulator CPU core on a req/ack unified memory.
// Ports: clk/rst_n, mem_* handshake, acc/carry/zero/pc/halted/out_of_bounds.
module accu_core_hs #(
  parameter int DATA_SIZE    = 8,
  parameter int ADDR_SIZE    = 5,
  parameter int OPCODE_SIZE  = 4,
  parameter int INSTR_SIZE   = 12,
  parameter int PROGRAM_SIZE = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_SIZE-1:0]          mem_addr,
  output logic [DATA_SIZE-1:0]          mem_wdata,
  input  logic [INSTR_SIZE-1:0]         mem_rdata,
  input  logic                          mem_ack,
  output logic [DATA_SIZE-1:0]          acc,
  output logic                          carry,
  output logic                          zero,
  output logic [$clog2(PROGRAM_SIZE):0] pc,
  output logic                          halted,
  output logic                          out_of_bounds
);

  localparam int PA = $clog2(PROGRAM_SIZE);
  localparam int PW = PA + 1;
  localparam int TW = PA + 2;

  localparam logic [OPCODE_SIZE-1:0] OP_HALT  = OPCODE_SIZE'(0);
  localparam logic [OPCODE_SIZE-1:0] OP_LOAD  = OPCODE_SIZE'(1);
  localparam logic [OPCODE_SIZE-1:0] OP_ADD   = OPCODE_SIZE'(2);
  localparam logic [OPCODE_SIZE-1:0] OP_SUB   = OPCODE_SIZE'(3);
  localparam logic [OPCODE_SIZE-1:0] OP_AND   = OPCODE_SIZE'(4);
  localparam logic [OPCODE_SIZE-1:0] OP_OR    = OPCODE_SIZE'(5);
  localparam logic [OPCODE_SIZE-1:0] OP_XOR   = OPCODE_SIZE'(6);
  localparam logic [OPCODE_SIZE-1:0] OP_NOT   = OPCODE_SIZE'(7);
  localparam logic [OPCODE_SIZE-1:0] OP_SHR   = OPCODE_SIZE'(8);
  localparam logic [OPCODE_SIZE-1:0] OP_SHL   = OPCODE_SIZE'(9);
  localparam logic [OPCODE_SIZE-1:0] OP_LDI   = OPCODE_SIZE'(10);
  localparam logic [OPCODE_SIZE-1:0] OP_ADDI  = OPCODE_SIZE'(11);
  localparam logic [OPCODE_SIZE-1:0] OP_STORE = OPCODE_SIZE'(12);
  localparam logic [OPCODE_SIZE-1:0] OP_JZ    = OPCODE_SIZE'(13);
  localparam logic [OPCODE_SIZE-1:0] OP_JN    = OPCODE_SIZE'(14);
  localparam logic [OPCODE_SIZE-1:0] OP_JMP   = OPCODE_SIZE'(15);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t                state, state_n;
  logic [INSTR_SIZE-1:0] instr, instr_n;
  logic [DATA_SIZE-1:0]  acc_n;
  logic                  carry_n;
  logic [PA:0]           pc_n;
  logic                  oob, oob_n;

  logic [OPCODE_SIZE-1:0] op;
  logic [DATA_SIZE-1:0]   k, m;
  logic                   is_mem;
  logic                   done;
  logic                   oob_t;
  logic [DATA_SIZE:0]     add_m, add_k, sub_m;
  logic [TW-1:0]          seq_t, rel_t, jmp_t, tgt;

  assign op = instr[INSTR_SIZE-1 -: OPCODE_SIZE];
  assign k  = instr[DATA_SIZE-1:0];
  assign m  = mem_rdata[DATA_SIZE-1:0];

  assign is_mem = op inside {OP_LOAD, OP_ADD, OP_SUB, OP_AND,
                             OP_OR, OP_XOR, OP_STORE};

  assign add_m = {1'b0, acc} + {1'b0, m};
  assign add_k = {1'b0, acc} + {1'b0, k};
  assign sub_m = {1'b0, acc} - {1'b0, m};

  // One extra bit on top of pc so negative targets show up as MSB set.
  assign seq_t = {1'b0, pc} + TW'(1);
  assign rel_t = {1'b0, pc} + {instr[PA], instr[PA:0]};
  assign jmp_t = TW'(acc[PA-1:0]);

  // Request is gated by rst_n so it drops the moment reset asserts.
  assign mem_req = rst_n & ((state == S_FETCH) |
                            ((state == S_EXEC) & is_mem));
  assign mem_we  = rst_n & (state == S_EXEC) & (op == OP_STORE);
  assign mem_addr = (state == S_FETCH) ? ADDR_SIZE'(pc)
                                       : instr[ADDR_SIZE-1:0];
  assign mem_wdata = acc;

  assign zero          = (acc == '0);
  assign halted        = (state == S_HALT);
  assign out_of_bounds = oob;

  always_comb begin
    state_n = state;
    instr_n = instr;
    acc_n   = acc;
    carry_n = carry;
    pc_n    = pc;
    oob_n   = oob;
    done    = 1'b0;
    oob_t   = 1'b0;
    tgt     = seq_t;
    unique case (1'b1)
      (state == S_FETCH): begin
        if (mem_ack) begin
          instr_n = mem_rdata;
          state_n = S_EXEC;
        end
      end
      (state == S_EXEC): begin
        done = is_mem ? mem_ack : 1'b1;
        if (done) begin
          if (op == OP_HALT) begin
            state_n = S_HALT;
          end else begin
            unique case (op)
              OP_LOAD: acc_n = m;
              OP_ADD:  {carry_n, acc_n} = add_m;
              OP_SUB: begin
                acc_n   = sub_m[DATA_SIZE-1:0];
                carry_n = ~sub_m[DATA_SIZE];
              end
              OP_AND:  acc_n = acc & m;
              OP_OR:   acc_n = acc | m;
              OP_XOR:  acc_n = acc ^ m;
              OP_NOT:  acc_n = ~acc;
              OP_SHR: begin
                acc_n   = {acc[DATA_SIZE-1], acc[DATA_SIZE-1:1]};
                carry_n = acc[0];
              end
              OP_SHL: begin
                acc_n   = {acc[DATA_SIZE-2:0], 1'b0};
                carry_n = acc[DATA_SIZE-1];
              end
              OP_LDI:  acc_n = k;
              OP_ADDI: {carry_n, acc_n} = add_k;
              OP_JZ:   if (acc == '0) tgt = rel_t;
              OP_JN:   if (acc[DATA_SIZE-1]) tgt = rel_t;
              OP_JMP:  tgt = jmp_t;
              default: ;
            endcase
            pc_n  = tgt[PA:0];
            oob_t = tgt[TW-1] | (tgt[PA:0] >= PW'(PROGRAM_SIZE));
            if (oob_t) begin
              oob_n   = 1'b1;
              state_n = S_HALT;
            end else begin
              state_n = S_FETCH;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      instr <= '0;
      acc   <= '0;
      carry <= 1'b0;
      pc    <= '0;
      oob   <= 1'b0;
    end else begin
      state <= state_n;
      instr <= instr_n;
      acc   <= acc_n;
      carry <= carry_n;
      pc    <= pc_n;
      oob   <= oob_n;
    end
  end

endmodule

// File: tb/tb_accu_core_hs.sv
// tb_accu_core_hs: directed vectors and sequences for accu_core_hs.
// Memory model with programmable ack latency, write log, stability monitor.
module tb_accu_core_hs;

  localparam logic [3:0] HLT = 4'd0,  LD = 4'd1,  AD = 4'd2,  SB = 4'd3;
  localparam logic [3:0] AN  = 4'd4,  OR_ = 4'd5, XR = 4'd6,  NT = 4'd7;
  localparam logic [3:0] SR  = 4'd8,  SL = 4'd9,  LI = 4'd10, AI = 4'd11;
  localparam logic [3:0] ST  = 4'd12, JZ = 4'd13, JN = 4'd14, JM = 4'd15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        mem_req, mem_we, mem_ack;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [11:0] mem_rdata;
  logic [7:0]  acc;
  logic        carry, zero, halted, oob;
  logic [4:0]  pc;

  logic        req4, we4;
  logic [4:0]  addr4;
  logic [7:0]  wdata4, acc4;
  logic [11:0] rdata4;
  logic        carry4, zero4, halted4, oob4;
  logic [2:0]  pc4;

  accu_core_hs dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .acc(acc), .carry(carry), .zero(zero), .pc(pc),
    .halted(halted), .out_of_bounds(oob)
  );

  accu_core_hs #(.PROGRAM_SIZE(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .mem_req(req4), .mem_we(we4), .mem_addr(addr4),
    .mem_wdata(wdata4), .mem_rdata(rdata4), .mem_ack(1'b1),
    .acc(acc4), .carry(carry4), .zero(zero4), .pc(pc4),
    .halted(halted4), .out_of_bounds(oob4)
  );

  logic [11:0] mem [32];
  logic [11:0] prog4 [32];
  logic [7:0]  dmem [32];
  int          dtag [32];
  int          gen = 1;
  int          lat = 0;
  int          cnt = 0;
  int          wcnt = 0;
  logic [4:0]  wa;
  logic [7:0]  wd;
  int          viol = 0;
  logic        prv = 1'b0;
  logic [4:0]  pa;
  logic        pwe;

  assign mem_rdata = (dtag[mem_addr] == gen) ? {4'b0, dmem[mem_addr]}
                                             : mem[mem_addr];
  assign mem_ack = mem_req && (cnt >= lat);
  assign rdata4  = prog4[addr4];

  always @(posedge clk) begin
    if (!rst_n || !mem_req || mem_ack) cnt <= 0;
    else cnt <= cnt + 1;
    if (mem_req && mem_ack && mem_we) begin
      dmem[mem_addr] <= mem_wdata;
      dtag[mem_addr] <= gen;
      wcnt <= wcnt + 1;
      wa   <= mem_addr;
      wd   <= mem_wdata;
    end
    if (prv && mem_req && (mem_addr !== pa || mem_we !== pwe))
      viol <= viol + 1;
    prv <= mem_req && !mem_ack;
    pa  <= mem_addr;
    pwe <= mem_we;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] ins(input logic [3:0] op,
                                      input logic [7:0] k);
    return {op, k};
  endfunction

  task automatic newprog();
    gen++;
    for (int i = 0; i < 32; i++) mem[i] = '0;
  endtask

  task automatic run(input int l, output int cyc);
    lat   = l;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    while (cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
      if (halted) break;
    end
    chk("halt reached", 32'(halted), 32'd1);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] m;
    logic       cset;
    logic [7:0] eacc;
    logic       ec;
  } vec_t;

  vec_t vt [16];

  initial begin
    int cyc, w0, v0, p;
    logic [7:0] opnd;

    for (int i = 0; i < 32; i++) prog4[i] = '0;
    prog4[0] = ins(LI, 8'h01);
    prog4[1] = ins(AI, 8'h01);
    prog4[2] = ins(AI, 8'h01);
    prog4[3] = ins(AI, 8'h01);

    vt[0]  = '{AD,  8'h05, 8'h03, 1'b0, 8'h08, 1'b0};
    vt[1]  = '{AD,  8'hF0, 8'h20, 1'b0, 8'h10, 1'b1};
    vt[2]  = '{SB,  8'h10, 8'h20, 1'b0, 8'hF0, 1'b0};
    vt[3]  = '{SB,  8'h20, 8'h20, 1'b0, 8'h00, 1'b1};
    vt[4]  = '{AN,  8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0};
    vt[5]  = '{OR_, 8'hF0, 8'h0F, 1'b1, 8'hFF, 1'b1};
    vt[6]  = '{XR,  8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0};
    vt[7]  = '{NT,  8'h0F, 8'h00, 1'b1, 8'hF0, 1'b1};
    vt[8]  = '{SR,  8'h81, 8'h00, 1'b0, 8'hC0, 1'b1};
    vt[9]  = '{SR,  8'h40, 8'h00, 1'b1, 8'h20, 1'b0};
    vt[10] = '{SL,  8'h81, 8'h00, 1'b0, 8'h02, 1'b1};
    vt[11] = '{SL,  8'h40, 8'h00, 1'b1, 8'h80, 1'b0};
    vt[12] = '{LI,  8'h12, 8'h00, 1'b1, 8'h00, 1'b1};
    vt[13] = '{AI,  8'hF0, 8'h20, 1'b0, 8'h10, 1'b1};
    vt[14] = '{AI,  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vt[15] = '{LD,  8'hAA, 8'h55, 1'b1, 8'h55, 1'b1};

    // reset state
    newprog();
    rst_n = 1'b0;
    lat   = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst acc", 32'(acc), 32'd0);
    chk("rst carry", 32'(carry), 32'd0);
    chk("rst zero", 32'(zero), 32'd1);
    chk("rst pc", 32'(pc), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst oob", 32'(oob), 32'd0);
    chk("rst req", 32'(mem_req), 32'd0);
    chk("rst we", 32'(mem_we), 32'd0);

    // single-op vectors
    for (int i = 0; i < 16; i++) begin
      newprog();
      p = 0;
      if (vt[i].cset) begin
        mem[0] = ins(LI, 8'hFF);
        mem[1] = ins(AI, 8'h01);
        p = 2;
      end
      opnd = (vt[i].op inside {LD, AD, SB, AN, OR_, XR}) ? 8'd20
                                                         : vt[i].m;
      mem[p]     = ins(LI, vt[i].a);
      mem[p + 1] = ins(vt[i].op, opnd);
      mem[p + 2] = ins(HLT, 8'h00);
      mem[20]    = {4'b0, vt[i].m};
      run(0, cyc);
      chk($sformatf("v%0d acc", i), 32'(acc), 32'(vt[i].eacc));
      chk($sformatf("v%0d carry", i), 32'(carry), 32'(vt[i].ec));
      chk($sformatf("v%0d zero", i), 32'(zero),
          32'(vt[i].eacc == 8'h00));
      chk($sformatf("v%0d pc", i), 32'(pc), 32'(p + 2));
    end

    // test 1: zero-wait timing
    newprog();
    mem[0]  = ins(LI, 8'h05);
    mem[1]  = ins(AD, 8'd20);
    mem[2]  = ins(HLT, 8'h00);
    mem[20] = 12'h003;
    run(0, cyc);
    chk("t1 cycles", 32'(cyc), 32'd6);
    chk("t1 acc", 32'(acc), 32'h08);
    chk("t1 carry", 32'(carry), 32'd0);
    chk("t1 pc", 32'(pc), 32'd2);
    chk("t1 oob", 32'(oob), 32'd0);
    chk("t1 req", 32'(mem_req), 32'd0);

    // test 3: three wait states on every request
    v0 = viol;
    run(3, cyc);
    chk("t3 cycles", 32'(cyc), 32'd18);
    chk("t3 acc", 32'(acc), 32'h08);
    chk("t3 carry", 32'(carry), 32'd0);
    chk("t3 pc", 32'(pc), 32'd2);
    chk("t3 stable", 32'(viol - v0), 32'd0);

    // test 2: ADDI carry then SUB borrow
    newprog();
    mem[0] = ins(LI, 8'hF0);
    mem[1] = ins(AI, 8'h20);
    mem[2] = ins(HLT, 8'h00);
    run(0, cyc);
    chk("t2a acc", 32'(acc), 32'h10);
    chk("t2a carry", 32'(carry), 32'd1);
    mem[2]  = ins(SB, 8'd20);
    mem[3]  = ins(HLT, 8'h00);
    mem[20] = 12'h020;
    run(0, cyc);
    chk("t2b acc", 32'(acc), 32'hF0);
    chk("t2b carry", 32'(carry), 32'd0);
    chk("t2b pc", 32'(pc), 32'd3);

    // test 4: countdown loop through memory, JZ exit
    newprog();
    mem[0] = ins(LI, 8'h03);
    mem[1] = ins(ST, 8'd20);
    mem[2] = ins(LD, 8'd20);
    mem[3] = ins(AI, 8'hFF);
    mem[4] = ins(JZ, 8'h04);
    mem[5] = ins(ST, 8'd20);
    mem[6] = ins(LI, 8'h02);
    mem[7] = ins(JM, 8'h00);
    mem[8] = ins(HLT, 8'h00);
    w0 = wcnt;
    run(0, cyc);
    chk("t4 acc", 32'(acc), 32'h00);
    chk("t4 zero", 32'(zero), 32'd1);
    chk("t4 pc", 32'(pc), 32'd8);
    chk("t4 oob", 32'(oob), 32'd0);
    chk("t4 writes", 32'(wcnt - w0), 32'd3);
    chk("t4 mem20", 32'(dmem[20]), 32'h01);

    // negative branch target leaves the program
    newprog();
    mem[0] = ins(LI, 8'h80);
    mem[1] = ins(JN, 8'h1C);
    run(0, cyc);
    chk("neg oob", 32'(oob), 32'd1);
    chk("neg pc", 32'(pc), 32'h1D);
    chk("neg req", 32'(mem_req), 32'd0);

    // test 5: store then reload
    newprog();
    mem[0] = ins(LI, 8'h07);
    mem[1] = ins(ST, 8'd25);
    mem[2] = ins(LI, 8'h00);
    mem[3] = ins(LD, 8'd25);
    mem[4] = ins(HLT, 8'h00);
    w0 = wcnt;
    run(0, cyc);
    chk("t5 writes", 32'(wcnt - w0), 32'd1);
    chk("t5 waddr", 32'(wa), 32'd25);
    chk("t5 wdata", 32'(wd), 32'h07);
    chk("t5 acc", 32'(acc), 32'h07);

    // test 6: reset during a stalled STORE
    newprog();
    mem[0] = ins(LI, 8'h09);
    mem[1] = ins(ST, 8'd26);
    mem[2] = ins(HLT, 8'h00);
    lat   = 3;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    w0 = wcnt;
    cyc = 0;
    while (!(mem_req && mem_we) && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6 store req", 32'(mem_req && mem_we), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6 req drop", 32'(mem_req), 32'd0);
    chk("t6 we drop", 32'(mem_we), 32'd0);
    chk("t6 acc", 32'(acc), 32'd0);
    chk("t6 pc", 32'(pc), 32'd0);
    repeat (3) @(negedge clk);
    chk("t6 no write", 32'(wcnt - w0), 32'd0);
    chk("t6 mem26", 32'(dtag[26] == gen), 32'd0);
    lat   = 0;
    rst_n = 1'b1;
    #1;
    chk("t6 refetch req", 32'(mem_req), 32'd1);
    chk("t6 refetch addr", 32'(mem_addr), 32'd0);
    chk("t6 refetch we", 32'(mem_we), 32'd0);

    // test 7: small program runs off its end
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t7 pc", 32'(pc4), 32'd4);
    chk("t7 oob", 32'(oob4), 32'd1);
    chk("t7 halted", 32'(halted4), 32'd1);
    chk("t7 acc", 32'(acc4), 32'h04);
    chk("t7 req", 32'(req4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
